// File: rtl/rx_pack_fifo_pkg.sv
// Shared QSPI receive-path constants: word width, byte lanes per word and default FIFO depth.
package rx_pack_fifo_pkg;
    localparam int DATA_W    = 32;
    localparam int NUM_BYTES = 4;
    localparam int DEF_DEPTH = 16;
endpackage

// File: rtl/rx_byte_packer.sv
// Packs received QSPI bytes little-endian into 32-bit words and raises a push
// on the 4th byte or on a flush of a partial word.
module rx_byte_packer
    import rx_pack_fifo_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    input  logic              flush_i,
    input  logic              clr_i,
    output logic              push_o,
    output logic [DATA_W-1:0] push_data_o
);
    logic [1:0]        idx;
    logic [DATA_W-1:0] pack_q;

    // Lanes above idx are always zero, so a flushed partial word is zero-padded for free.
    always_comb begin
        push_data_o = pack_q;
        if (byte_valid_i)
            push_data_o[8*idx +: 8] = byte_i;
        push_o = !clr_i &&
                 ((byte_valid_i && idx == 2'(NUM_BYTES - 1)) ||
                  (flush_i && (byte_valid_i || idx != 2'd0)));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx    <= 2'd0;
            pack_q <= '0;
        end else if (clr_i || push_o) begin
            idx    <= 2'd0;
            pack_q <= '0;
        end else if (byte_valid_i) begin
            idx    <= idx + 2'd1;
            pack_q <= push_data_o;
        end
    end
endmodule

// File: rtl/rx_pack_fifo.sv
// QSPI receive FIFO: byte packer feeding a DEPTH x 32-bit word FIFO with
// registered pop data, level/threshold flags and a sticky overflow flag.
module rx_pack_fifo
    import rx_pack_fifo_pkg::*;
#(
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    input  logic              flush_i,
    input  logic              clr_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    input  logic [AW:0]       thresh_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [AW:0]       level_o,
    output logic              thresh_o,
    output logic              ovf_o,
    input  logic              ovf_clr_i
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr, rptr;
    logic [AW:0]       count;
    logic              push_req;
    logic [DATA_W-1:0] push_data;
    logic              push_ok, pop_ok, overflow;

    rx_byte_packer u_packer (
        .clk          (clk),
        .resetn       (resetn),
        .byte_valid_i (byte_valid_i),
        .byte_i       (byte_i),
        .flush_i      (flush_i),
        .clr_i        (clr_i),
        .push_o       (push_req),
        .push_data_o  (push_data)
    );

    assign full_o   = (count == (AW+1)'(DEPTH));
    assign empty_o  = (count == '0);
    assign level_o  = count;
    assign thresh_o = (thresh_i != '0) && (count >= thresh_i);

    // Full is judged on the start-of-cycle count; a same-cycle pop does not make room.
    assign push_ok  = push_req && !full_o;
    assign overflow = push_req &&  full_o;
    assign pop_ok   = rd_en_i && !empty_o && !clr_i;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wptr] <= push_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clr_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_data_o  <= '0;
            rd_valid_o <= 1'b0;
        end else begin
            rd_valid_o <= pop_ok;
            if (pop_ok)
                rd_data_o <= mem[rptr];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            ovf_o <= 1'b0;
        else if (overflow)
            ovf_o <= 1'b1;
        else if (ovf_clr_i)
            ovf_o <= 1'b0;
    end
endmodule

// File: tb/tb_rx_pack_fifo.sv
// Randomized and directed bench for rx_pack_fifo against a queue-based model
// of bytes-in / words-out behaviour.
module tb_rx_pack_fifo;
    import rx_pack_fifo_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic              clk = 1'b0;
    logic              resetn;
    logic              byte_valid_i, flush_i, clr_i, rd_en_i, ovf_clr_i;
    logic [7:0]        byte_i;
    logic [DATA_W-1:0] rd_data_o;
    logic              rd_valid_o, full_o, empty_o, thresh_o, ovf_o;
    logic [AW:0]       thresh_i, level_o;

    rx_pack_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .byte_valid_i(byte_valid_i), .byte_i(byte_i),
        .flush_i(flush_i), .clr_i(clr_i), .rd_en_i(rd_en_i), .rd_data_o(rd_data_o),
        .rd_valid_o(rd_valid_o), .thresh_i(thresh_i), .full_o(full_o), .empty_o(empty_o),
        .level_o(level_o), .thresh_o(thresh_o), .ovf_o(ovf_o), .ovf_clr_i(ovf_clr_i)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [7:0]  part_q[$];
    logic [31:0] fifo_q[$];
    logic [31:0] m_rd_data = '0;
    logic        m_rd_valid = 1'b0;
    logic        m_ovf = 1'b0;
    int          m_words = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        part_q.delete();
        fifo_q.delete();
        m_rd_data  = '0;
        m_rd_valid = 1'b0;
        m_ovf      = 1'b0;
    endtask

    task automatic check_all();
        int lvl = fifo_q.size();
        chk("level",    32'(level_o),    32'(lvl));
        chk("full",     32'(full_o),     32'(lvl == DEPTH));
        chk("empty",    32'(empty_o),    32'(lvl == 0));
        chk("thresh",   32'(thresh_o),   32'(thresh_i != 0 && lvl >= int'(thresh_i)));
        chk("rd_valid", 32'(rd_valid_o), 32'(m_rd_valid));
        chk("rd_data",  rd_data_o,       m_rd_data);
        chk("ovf",      32'(ovf_o),      32'(m_ovf));
    endtask

    // One clock: drive inputs, advance the model, take the edge, compare.
    task automatic step(input logic bv, input logic [7:0] b, input logic fl,
                        input logic cl, input logic rd, input logic oc);
        logic        full_before;
        logic        ovf_set;
        logic [31:0] w;
        byte_valid_i = bv; byte_i = b; flush_i = fl;
        clr_i = cl; rd_en_i = rd; ovf_clr_i = oc;
        ovf_set = 1'b0;
        if (cl) begin
            part_q.delete();
            fifo_q.delete();
            m_rd_valid = 1'b0;
        end else begin
            full_before = (fifo_q.size() == DEPTH);
            m_rd_valid  = rd && fifo_q.size() > 0;
            if (m_rd_valid)
                m_rd_data = fifo_q.pop_front();
            if (bv)
                part_q.push_back(b);
            if (part_q.size() == 4 || (fl && part_q.size() > 0)) begin
                w = '0;
                foreach (part_q[i])
                    w = w | (32'(part_q[i]) << (8 * i));
                m_words++;
                if (full_before) ovf_set = 1'b1;
                else             fifo_q.push_back(w);
                part_q.delete();
            end
        end
        if (ovf_set)  m_ovf = 1'b1;
        else if (oc)  m_ovf = 1'b0;
        @(posedge clk);
        #1;
        check_all();
        byte_valid_i = 0; byte_i = '0; flush_i = 0; clr_i = 0; rd_en_i = 0; ovf_clr_i = 0;
    endtask

    task automatic push_word(input logic [31:0] w, input logic rd_last);
        for (int i = 0; i < 4; i++)
            step(1'b1, w[8*i +: 8], 1'b0, 1'b0, (i == 3) ? rd_last : 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2 && fifo_q.size() > 0; i++)
            step(0, 8'h00, 0, 0, 1, 0);
        chk("drained", 32'(empty_o), 32'd1);
    endtask

    initial begin
        resetn = 1'b0;
        byte_valid_i = 0; byte_i = '0; flush_i = 0; clr_i = 0;
        rd_en_i = 0; ovf_clr_i = 0; thresh_i = '0;
        model_reset();
        #12;
        check_all();
        resetn = 1'b1;
        step(0, 8'h00, 0, 0, 1, 0);   // pop on empty: ignored

        // four bytes, then pop
        push_word(32'h44332211, 1'b0);
        chk("lvl_one", 32'(level_o), 32'd1);
        step(0, 8'h00, 0, 0, 1, 0);
        chk("pop_word", rd_data_o, 32'h44332211);
        chk("pop_vld", 32'(rd_valid_o), 32'd1);
        chk("pop_lvl", 32'(level_o), 32'd0);
        step(0, 8'h00, 0, 0, 0, 0);

        // partial word flush, redundant flush, then byte+flush in one cycle
        step(1, 8'hAA, 0, 0, 0, 0);
        step(1, 8'hBB, 0, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0, 0);
        chk("flush_lvl", 32'(level_o), 32'd1);
        step(0, 8'h00, 1, 0, 0, 0);
        chk("flush_noop", 32'(level_o), 32'd1);
        step(0, 8'h00, 0, 0, 1, 0);
        chk("flush_word", rd_data_o, 32'h0000BBAA);
        step(1, 8'h5A, 0, 0, 0, 0);
        step(1, 8'hC3, 1, 0, 0, 0);
        chk("bv_flush_lvl", 32'(level_o), 32'd1);
        step(0, 8'h00, 0, 0, 1, 0);
        chk("bv_flush_word", rd_data_o, 32'h0000C35A);

        // fill to full with threshold 8, then overflow with concurrent pop
        thresh_i = 5'd8;
        for (int i = 0; i < DEPTH; i++) begin
            push_word(32'hA0B0C000 + 32'(i), 1'b0);
            chk("thresh_rise", 32'(thresh_o), 32'(i + 1 >= 8));
        end
        chk("full16", 32'(full_o), 32'd1);
        step(1, 8'hE1, 0, 0, 0, 0);
        step(1, 8'hE2, 0, 0, 0, 0);
        step(1, 8'hE3, 0, 0, 0, 0);
        step(1, 8'hE4, 0, 0, 1, 0);
        chk("ovf17", 32'(ovf_o), 32'd1);
        chk("lvl15", 32'(level_o), 32'd15);
        chk("pop_first", rd_data_o, 32'hA0B0C000);
        step(0, 8'h00, 0, 0, 0, 1);
        chk("ovf_clr", 32'(ovf_o), 32'd0);
        // refill to full, then overflow while clearing: set wins
        push_word(32'h12345678, 1'b0);
        step(1, 8'h01, 0, 0, 0, 0);
        step(1, 8'h02, 1, 0, 0, 1);
        chk("ovf_set_wins", 32'(ovf_o), 32'd1);
        drain();

        // clear at level 5 with concurrent byte and pop; ovf stays set
        for (int i = 0; i < 5; i++)
            push_word(32'h0F0E0D00 + 32'(i), 1'b0);
        step(1, 8'h99, 0, 0, 0, 0);
        step(1, 8'h77, 0, 1, 1, 0);
        chk("clr_lvl", 32'(level_o), 32'd0);
        chk("clr_vld", 32'(rd_valid_o), 32'd0);
        chk("clr_ovf", 32'(ovf_o), 32'd1);
        push_word(32'hCAFEF00D, 1'b0);
        step(0, 8'h00, 0, 0, 1, 0);
        chk("clr_fresh", rd_data_o, 32'hCAFEF00D);

        // asynchronous reset in mid-word, away from the clock edge
        step(1, 8'h55, 0, 0, 0, 0);
        step(1, 8'h66, 0, 0, 0, 0);
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        chk("rst_data", rd_data_o, 32'h0);
        chk("rst_lvl", 32'(level_o), 32'd0);
        chk("rst_ovf", 32'(ovf_o), 32'd0);
        chk("rst_empty", 32'(empty_o), 32'd1);
        @(negedge clk);
        resetn = 1'b1;
        push_word(32'h04030201, 1'b0);
        step(0, 8'h00, 0, 0, 1, 0);
        chk("rst_word", rd_data_o, 32'h04030201);

        // random stream of 40 words, ~1-in-3 pops, random flush/threshold
        m_words = 0;
        for (int cyc = 0; cyc < 4000 && m_words < 40; cyc++) begin
            if ($urandom_range(0, 31) == 0) thresh_i = 5'($urandom_range(0, DEPTH));
            step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 7) == 0),
                 1'b0, ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
        end
        chk("stream_words", 32'(m_words >= 40), 32'd1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
